param_updown_counter: RTL and testbench

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/param_updown_counter.sv | 90 +++++++++
 tb/tb_param_updown_counter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with prescaler, load/clear, terminal-count pulse,
// sticky boundary flag and a combinational compare output.
module param_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX      = 2**WIDTH-1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             match,
  output logic             ovf
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             boundary_s;

  // Next-state: clear beats load beats step; tc is a pulse so it defaults low.
  always_comb begin
    count_d    = count_q;
    pre_d      = pre_q;
    tc_d       = 1'b0;
    ovf_d      = ovf_q;
    boundary_s = up ? (count_q == MAX_C) : (count_q == {WIDTH{1'b0}});
    if (clr) begin
      count_d = {WIDTH{1'b0}};
      pre_d   = {PW{1'b0}};
      ovf_d   = 1'b0;
    end else if (load) begin
      pre_d   = {PW{1'b0}};
      ovf_d   = 1'b0;
      count_d = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (en) begin
      if (pre_q == PRE_LAST) begin
        pre_d = {PW{1'b0}};
        if (boundary_s) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (SATURATE != 0) begin
            count_d = count_q;
          end else begin
            count_d = up ? {WIDTH{1'b0}} : MAX_C;
          end
        end else begin
          count_d = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end else begin
      pre_d = pre_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {WIDTH{1'b0}};
      pre_q   <= {PW{1'b0}};
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign match = (count_q == cmp_val);

endmodule

// File: tb/tb_param_updown_counter.sv
// Randomised plus directed bench: three counter configurations share one stimulus
// stream and are checked against an arithmetic reference model.
module tb_param_updown_counter;

  localparam int N   = 3;
  localparam int MAX = 9;
  localparam int P_PRE [N] = '{1, 1, 3};
  localparam int P_SAT [N] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0, cmp_val = 4'd0;
  logic [3:0] cnt_o [N];
  logic       tc_o [N], match_o [N], ovf_o [N];

  int n_cmp = 0;
  int n_err = 0;
  int m_cnt [N], m_pre [N], m_tc [N], m_ovf [N];

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MAX(MAX), .PRESCALE(1), .SATURATE(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .cmp_val(cmp_val), .count(cnt_o[0]), .tc(tc_o[0]), .match(match_o[0]), .ovf(ovf_o[0]));
  param_updown_counter #(.WIDTH(4), .MAX(MAX), .PRESCALE(1), .SATURATE(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .cmp_val(cmp_val), .count(cnt_o[1]), .tc(tc_o[1]), .match(match_o[1]), .ovf(ovf_o[1]));
  param_updown_counter #(.WIDTH(4), .MAX(MAX), .PRESCALE(3), .SATURATE(0)) u_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .cmp_val(cmp_val), .count(cnt_o[2]), .tc(tc_o[2]), .match(match_o[2]), .ovf(ovf_o[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end
  endtask

  // Reference behaviour: wrap computed with modular arithmetic over 0..MAX.
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      bit bnd;
      m_tc[i] = 0;
      if (clr) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        m_pre[i] = 0; m_ovf[i] = 0;
        m_cnt[i] = (int'(load_val) > MAX) ? MAX : int'(load_val);
      end else if (en) begin
        if (m_pre[i] + 1 == P_PRE[i]) begin
          m_pre[i] = 0;
          bnd = up ? (m_cnt[i] == MAX) : (m_cnt[i] == 0);
          if (bnd) begin
            m_tc[i] = 1; m_ovf[i] = 1;
          end
          if (!(bnd && P_SAT[i] == 1))
            m_cnt[i] = up ? (m_cnt[i] + 1) % (MAX + 1) : (m_cnt[i] + MAX) % (MAX + 1);
        end else begin
          m_pre[i] = m_pre[i] + 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("count%0d", i), int'(cnt_o[i]), m_cnt[i]);
      chk($sformatf("tc%0d", i), int'(tc_o[i]), m_tc[i]);
      chk($sformatf("ovf%0d", i), int'(ovf_o[i]), m_ovf[i]);
      chk($sformatf("match%0d", i), int'(match_o[i]), int'(m_cnt[i] == int'(cmp_val)));
    end
  endtask

  // One clock: inputs set after the falling edge, outputs checked 1 time unit after the rising edge.
  task automatic cyc(input logic e, input logic u, input logic c, input logic l, input logic [3:0] lv);
    en = e; up = u; clr = c; load = l; load_val = lv;
    @(posedge clk);
    model_edge();
    #1 compare_all();
    @(negedge clk);
  endtask

  // Reset asserted between edges, held across one rising edge, released on a falling edge.
  task automatic arst();
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all();
    chk("rst_match", int'(match_o[0]), int'(cmp_val == 4'd0));
    en = 1'b1; load = 1'b1; load_val = 4'd7;
    @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Wrap up-count from reset.
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      chk("wrap_cnt", int'(cnt_o[0]), k % 10);
      chk("wrap_tc", int'(tc_o[0]), int'(k == 10));
      chk("wrap_ovf", int'(ovf_o[0]), int'(k >= 10));
    end

    // Down underflow then load clears ovf.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("under_cnt", int'(cnt_o[0]), 9);
    chk("under_tc", int'(tc_o[0]), 1);
    chk("under_ovf", int'(ovf_o[0]), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
    chk("load_cnt", int'(cnt_o[0]), 3);
    chk("load_ovf", int'(ovf_o[0]), 0);
    chk("load_tc", int'(tc_o[0]), 0);

    // Saturating instance held at MAX.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd8);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      chk("sat_cnt", int'(cnt_o[1]), 9);
      chk("sat_tc", int'(tc_o[1]), int'(k >= 2));
      chk("sat_ovf", int'(ovf_o[1]), int'(k >= 2));
    end

    // Prescaled stepping from reset, with an enable gap.
    arst();
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      if (k % 3 == 0) chk("pre_cnt", int'(cnt_o[2]), k / 3);
    end
    arst();
    for (int k = 1; k <= 11; k++) cyc(k != 8 && k != 9, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("pre_gap", int'(cnt_o[2]), 3);

    // Priority: over-range load, clr with load, load on a step edge.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd12);
    chk("load_clamp", int'(cnt_o[0]), 9);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    chk("clr_load", int'(cnt_o[0]), 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
    chk("load_step", int'(cnt_o[0]), 5);

    // Compare then asynchronous reset.
    cmp_val = 4'd5;
    #1 chk("match5", int'(match_o[0]), 1);
    arst();
    chk("rst_cnt", int'(cnt_o[0]), 0);

    // Randomised run.
    for (int k = 0; k < 400; k++) begin
      cmp_val = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 60) == 0) arst();
      else cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 25) == 0), 1'($urandom_range(0, 12) == 0),
               4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
